// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite master blocks:
//   loader_state_e : state encoding of the BRAM loader FSM
//   RESP_OKAY      : AXI OKAY response code
//   WSTRB_ALL      : full-word write strobe
//   PROT_DEFAULT   : unprivileged, secure, data access
//   resp_is_error  : true for any response other than OKAY
// -----------------------------------------------------------------------------
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RESP   = 3'd3,
    ST_RDREQ  = 3'd4,
    ST_RDRESP = 3'd5,
    ST_DONE   = 3'd6
  } loader_state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [3:0] WSTRB_ALL    = 4'b1111;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_wr_chan.sv
// -----------------------------------------------------------------------------
// axil_wr_chan
// Tracks the independent AW and W handshakes of one AXI4-Lite write.
// A launch pulse raises both valids; each valid drops the cycle after its own
// handshake, so AW-first, W-first and simultaneous acceptance all work.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   launch              : one-cycle pulse starting a new write
//   awready, wready     : slave ready inputs
//   awvalid, wvalid     : master valid outputs
//   aw_done, w_done     : registered "channel accepted" flags for this write
//   both_done           : both channels accepted (includes a handshake
//                         happening in the current cycle)
// -----------------------------------------------------------------------------
module axil_wr_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic aw_done,
  output logic w_done,
  output logic both_done
);

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // AW channel: raise on launch, retire on its own handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid <= 1'b0;
      aw_done <= 1'b0;
    end else if (launch) begin
      awvalid <= 1'b1;
      aw_done <= 1'b0;
    end else if (aw_hs) begin
      awvalid <= 1'b0;
      aw_done <= 1'b1;
    end
  end

  // W channel: same life cycle, independent of AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wvalid <= 1'b0;
      w_done <= 1'b0;
    end else if (launch) begin
      wvalid <= 1'b1;
      w_done <= 1'b0;
    end else if (w_hs) begin
      wvalid <= 1'b0;
      w_done <= 1'b1;
    end
  end

  // Counting the in-flight handshake lets the owner move on without an
  // extra idle cycle after the last channel is accepted.
  assign both_done = (aw_done | aw_hs) & (w_done | w_hs);

endmodule

// File: rtl/axil_bram_loader.sv
// -----------------------------------------------------------------------------
// axil_bram_loader
// AXI4-Lite write master feeding an AXI BRAM controller. Each word accepted
// from the valid/ready stream is written to BASE_ADDR + 4*n, one transaction
// at a time. A done pulse marks the end of a NUM_WORDS load; err is sticky
// until the next accepted start.
// Optional build macro: AXIL_LOADER_READBACK_EN -- reads every word back
// after its write response and flags err on a bad response or data mismatch.
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, asynchronous active-low reset
//   start                     : begins a load when idle
//   in_data/in_valid/in_ready : input word stream
//   m_axi_aw*/w*/b*           : AXI4-Lite write channels
//   m_axi_ar*/r*              : AXI4-Lite read channels (readback only)
//   busy, done, err           : load status
//   word_count                : words completed in the current load
// -----------------------------------------------------------------------------
module axil_bram_loader
  import axil_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_WORDS = 1024,
  localparam int               CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);

  loader_state_e state;
  loader_state_e state_next;
  logic          launch;
  logic          aw_done;
  logic          w_done;
  logic          both_done;
  logic          last_word;
  logic          unused_ok;

  assign m_axi_awprot = PROT_DEFAULT;
  assign m_axi_wstrb  = WSTRB_ALL;
  assign last_word    = (word_count == CNT_W'(NUM_WORDS - 1));

  axil_wr_chan u_wr_chan (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .launch    (launch),
    .awready   (m_axi_awready),
    .wready    (m_axi_wready),
    .awvalid   (m_axi_awvalid),
    .wvalid    (m_axi_wvalid),
    .aw_done   (aw_done),
    .w_done    (w_done),
    .both_done (both_done)
  );

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= ST_IDLE;
    else                state <= state_next;
  end

  // Next state and the handshake outputs that follow directly from the state.
  always_comb begin
    state_next   = state;
    launch       = 1'b0;
    in_ready     = 1'b0;
    m_axi_bready = 1'b0;
    done         = 1'b0;
`ifdef AXIL_LOADER_READBACK_EN
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          launch     = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: if (both_done) state_next = ST_RESP;
      ST_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
`ifdef AXIL_LOADER_READBACK_EN
          state_next = ST_RDREQ;
`else
          state_next = last_word ? ST_DONE : ST_LOAD;
`endif
        end
      end
`ifdef AXIL_LOADER_READBACK_EN
      ST_RDREQ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = ST_RDRESP;
      end
      ST_RDRESP: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = last_word ? ST_DONE : ST_LOAD;
      end
`endif
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and status: the write address/data are captured together with
  // the stream word so they stay stable for the whole transaction.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      m_axi_awaddr <= BASE_ADDR;
      m_axi_wdata  <= '0;
      word_count   <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          word_count <= '0;
          err        <= 1'b0;
          busy       <= 1'b1;
        end
        ST_LOAD: if (in_valid) begin
          m_axi_wdata  <= in_data;
          m_axi_awaddr <= BASE_ADDR + ADDR_W'({word_count, 2'b00});
        end
        ST_RESP: if (m_axi_bvalid) begin
          if (resp_is_error(m_axi_bresp)) err <= 1'b1;
`ifndef AXIL_LOADER_READBACK_EN
          word_count <= word_count + CNT_W'(1);
`endif
        end
`ifdef AXIL_LOADER_READBACK_EN
        ST_RDRESP: if (m_axi_rvalid) begin
          if (resp_is_error(m_axi_rresp) || (m_axi_rdata != m_axi_wdata)) err <= 1'b1;
          word_count <= word_count + CNT_W'(1);
        end
`endif
        ST_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef AXIL_LOADER_READBACK_EN
  // The readback address tracks the address just written.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)                    m_axi_araddr <= BASE_ADDR;
    else if (state == ST_LOAD && in_valid) m_axi_araddr <= BASE_ADDR + ADDR_W'({word_count, 2'b00});
  end

  assign unused_ok = aw_done ^ w_done;
`else
  assign m_axi_araddr  = BASE_ADDR;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
  assign unused_ok = ^{aw_done, w_done, m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

endmodule

// File: tb/tb_axil_bram_loader.sv
// -----------------------------------------------------------------------------
// tb_axil_bram_loader
// Drives random word streams into axil_bram_loader (NUM_WORDS=5,
// BASE_ADDR=0x100) against an AXI BRAM slave model with programmable
// AW/W ready skew, error injection and readback corruption. Expected
// addresses, data, counts and status are derived from the load rules.
// Honors AXIL_LOADER_READBACK_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_axil_bram_loader;

  localparam int          ADDR_W     = 12;
  localparam int          DATA_W     = 32;
  localparam int          NW         = 5;
  localparam int          CNT_W      = $clog2(NW + 1);
  localparam logic [11:0] BASE       = 12'h100;
  localparam int          WAIT_LIMIT = 400;
  localparam logic [31:0] FIXED_DATA [NW] = '{32'h0000abcd, 32'h1111fade, 32'h2222cafe,
                                              32'h3333babe, 32'h4444feed};

  logic              s_axi_aclk = 1'b0;
  logic              s_axi_aresetn;
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [2:0]        m_axi_awprot;
  logic              m_axi_awvalid;
  logic              m_axi_awready = 1'b0;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready  = 1'b0;
  logic [1:0]        m_axi_bresp   = 2'b00;
  logic              m_axi_bvalid  = 1'b0;
  logic              m_axi_bready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready = 1'b0;
  logic [DATA_W-1:0] m_axi_rdata   = '0;
  logic [1:0]        m_axi_rresp   = 2'b00;
  logic              m_axi_rvalid  = 1'b0;
  logic              m_axi_rready;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  word_count;

  int n_checks = 0;
  int n_errors = 0;

  // Slave configuration, written only by the test sequence.
  int aw_delay     = 0;
  int w_delay      = 0;
  int err_addr     = -1;
  int corrupt_addr = -1;

  // Slave state and observations, written only by the slave process.
  int          aw_cnt = 0, w_cnt = 0;
  bit          aw_got = 0, w_got = 0, ar_got = 0;
  logic [11:0] got_addr, ar_addr_q;
  logic [31:0] got_data;
  bit          prev_awvalid = 0, prev_wvalid = 0, prev_bready = 0, prev_arvalid = 0, prev_rready = 0;
  logic [11:0] prev_awaddr, prev_araddr;
  logic [31:0] prev_wdata;
  logic [31:0] bram [0:1023];
  logic [11:0] log_addr [0:255];
  logic [31:0] log_data [0:255];
  logic [11:0] ar_log   [0:255];
  int          log_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, ar_cnt = 0;
  int          done_cnt = 0, stab_viol = 0, rdy_viol = 0;

  axil_bram_loader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE),
    .NUM_WORDS (NW)
  ) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .word_count    (word_count)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  // AXI BRAM slave model, acting on the falling edge: it first accounts for
  // handshakes that completed at the preceding rising edge, then sets up its
  // ready/valid outputs for the next rising edge.
  always @(negedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 2'b00;
      aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0;
      prev_awvalid = 0; prev_wvalid = 0; prev_bready = 0; prev_arvalid = 0; prev_rready = 0;
    end else begin
      if (m_axi_awready && prev_awvalid) begin
        aw_got = 1; got_addr = prev_awaddr; aw_hs_cnt++;
      end else if (prev_awvalid && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr)) stab_viol++;
      if (m_axi_wready && prev_wvalid) begin
        w_got = 1; got_data = prev_wdata; w_hs_cnt++;
      end else if (prev_wvalid && (!m_axi_wvalid || m_axi_wdata !== prev_wdata)) stab_viol++;
      if (m_axi_bvalid && prev_bready) m_axi_bvalid = 0;
      if (m_axi_arready && prev_arvalid) begin
        ar_got = 1; ar_addr_q = prev_araddr; ar_log[ar_cnt % 256] = prev_araddr; ar_cnt++;
      end
      if (m_axi_rvalid && prev_rready) m_axi_rvalid = 0;
      if (done) done_cnt++;
      if (in_ready && (m_axi_awvalid || m_axi_wvalid || m_axi_bready || m_axi_arvalid || m_axi_rready))
        rdy_viol++;
      if (aw_got && w_got) begin
        bram[got_addr[11:2]] = got_data;
        log_addr[log_cnt % 256] = got_addr;
        log_data[log_cnt % 256] = got_data;
        log_cnt++;
        m_axi_bresp  = (int'(got_addr) == err_addr) ? 2'b10 : 2'b00;
        m_axi_bvalid = 1;
        aw_got = 0; w_got = 0;
      end
      if (ar_got) begin
        m_axi_rdata  = (int'(ar_addr_q) == corrupt_addr) ? 32'hdeadbeef : bram[ar_addr_q[11:2]];
        m_axi_rresp  = 2'b00;
        m_axi_rvalid = 1;
        ar_got = 0;
      end
      if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin m_axi_awready = 0; aw_cnt = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_delay); w_cnt++; end
      else begin m_axi_wready = 0; w_cnt = 0; end
      m_axi_arready = m_axi_arvalid;
      prev_awvalid = m_axi_awvalid; prev_awaddr = m_axi_awaddr;
      prev_wvalid  = m_axi_wvalid;  prev_wdata  = m_axi_wdata;
      prev_bready  = m_axi_bready;
      prev_arvalid = m_axi_arvalid; prev_araddr = m_axi_araddr;
      prev_rready  = m_axi_rready;
    end
  end

  // Presents one stream word after an idle gap and returns once it has been
  // taken (ok=0 if in_ready never came).
  task automatic send_word(input logic [31:0] d, input int gap, output bit ok);
    int cyc;
    in_valid = 0;
    repeat (gap) @(negedge s_axi_aclk);
    in_valid = 1;
    in_data  = d;
    cyc = 0;
    while (!in_ready && cyc < WAIT_LIMIT) begin @(negedge s_axi_aclk); cyc++; end
    ok = in_ready;
    @(negedge s_axi_aclk);
    in_valid = 0;
  endtask

  // One complete load with its full set of expectations.
  task automatic do_load(input string name, input bit use_fixed, input int gap_max,
                         input int err_word, input int corrupt_word, input bit start_noise);
    logic [31:0] exp_data [NW];
    logic [11:0] exp_addr;
    int  base_log, base_done, base_aw, base_w, base_ar, cyc;
    bit  exp_err, ok;
    for (int i = 0; i < NW; i++) exp_data[i] = use_fixed ? FIXED_DATA[i] : $urandom;
    err_addr     = (err_word >= 0) ? int'(BASE) + 4 * err_word : -1;
    corrupt_addr = (corrupt_word >= 0) ? int'(BASE) + 4 * corrupt_word : -1;
    exp_err = (err_word >= 0);
`ifdef AXIL_LOADER_READBACK_EN
    if (corrupt_word >= 0) exp_err = 1;
`endif
    base_log = log_cnt; base_done = done_cnt; base_aw = aw_hs_cnt; base_w = w_hs_cnt; base_ar = ar_cnt;
    start = 1;
    @(negedge s_axi_aclk);
    start = 0;
    n_checks++;
    if (busy !== 1'b1 || word_count !== '0 || err !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL %s start_accept: busy=%b wc=%0d err=%b in_ready=%b, required 1,0,0,1",
               name, busy, word_count, err, in_ready);
    end
    for (int i = 0; i < NW; i++) begin
      if (start_noise && i == 2) begin
        start = 1; @(negedge s_axi_aclk); start = 0;
      end
      send_word(exp_data[i], $urandom_range(0, gap_max), ok);
      if (!ok) begin
        n_checks++; n_errors++;
        $display("[TB] FAIL %s stream_word%0d: in_ready timeout, required ready", name, i);
        return;
      end
    end
    cyc = 0;
    while (!done && cyc < WAIT_LIMIT) begin @(negedge s_axi_aclk); cyc++; end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL %s done_wait: done=%b busy=%b, required 1,1", name, done, busy);
      return;
    end
    if (start_noise) start = 1;
    @(negedge s_axi_aclk);
    start = 0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL %s idle_after_done: busy=%b in_ready=%b, required 0,0", name, busy, in_ready);
    end
    repeat (3) @(negedge s_axi_aclk);
    n_checks++;
    if (done_cnt - base_done !== 1 || word_count !== CNT_W'(NW) || err !== exp_err) begin
      n_errors++;
      $display("[TB] FAIL %s status: done_pulses=%0d wc=%0d err=%b, required 1,%0d,%b",
               name, done_cnt - base_done, word_count, err, NW, exp_err);
    end
    n_checks++;
    if (log_cnt - base_log !== NW || aw_hs_cnt - base_aw !== NW || w_hs_cnt - base_w !== NW) begin
      n_errors++;
      $display("[TB] FAIL %s write_count: writes=%0d aw=%0d w=%0d, required %0d each",
               name, log_cnt - base_log, aw_hs_cnt - base_aw, w_hs_cnt - base_w, NW);
    end
    for (int i = 0; i < NW; i++) begin
      exp_addr = BASE + 12'(4 * i);
      n_checks++;
      if (log_addr[(base_log + i) % 256] !== exp_addr || log_data[(base_log + i) % 256] !== exp_data[i]
          || bram[exp_addr[11:2]] !== exp_data[i]) begin
        n_errors++;
        $display("[TB] FAIL %s write%0d: addr=%h data=%h bram=%h, required addr=%h data=%h", name, i,
                 log_addr[(base_log + i) % 256], log_data[(base_log + i) % 256],
                 bram[exp_addr[11:2]], exp_addr, exp_data[i]);
      end
`ifdef AXIL_LOADER_READBACK_EN
      n_checks++;
      if (ar_log[(base_ar + i) % 256] !== exp_addr) begin
        n_errors++;
        $display("[TB] FAIL %s readback_addr%0d: araddr=%h, required %h", name, i,
                 ar_log[(base_ar + i) % 256], exp_addr);
      end
`endif
    end
`ifdef AXIL_LOADER_READBACK_EN
    n_checks++;
    if (ar_cnt - base_ar !== NW) begin
      n_errors++;
      $display("[TB] FAIL %s readback_count: ar=%0d, required %0d", name, ar_cnt - base_ar, NW);
    end
`endif
    n_checks++;
    if (stab_viol !== 0 || rdy_viol !== 0) begin
      n_errors++;
      $display("[TB] FAIL %s protocol: stability_violations=%0d in_ready_violations=%0d, required 0,0",
               name, stab_viol, rdy_viol);
    end
    err_addr = -1;
    corrupt_addr = -1;
  endtask

  task automatic test_reset;
    s_axi_aresetn = 0; start = 0; in_valid = 0; in_data = '0;
    repeat (3) @(negedge s_axi_aclk);
    n_checks++;
    if (m_axi_awvalid !== 0 || m_axi_wvalid !== 0 || m_axi_bready !== 0 || m_axi_arvalid !== 0 ||
        m_axi_rready !== 0 || in_ready !== 0) begin
      n_errors++;
      $display("[TB] FAIL reset_handshakes: aw=%b w=%b b=%b ar=%b r=%b in_ready=%b, required all 0",
               m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, in_ready);
    end
    n_checks++;
    if (busy !== 0 || done !== 0 || err !== 0 || word_count !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_status: busy=%b done=%b err=%b wc=%0d, required 0,0,0,0",
               busy, done, err, word_count);
    end
    n_checks++;
    if (m_axi_awaddr !== BASE || m_axi_araddr !== BASE || m_axi_wdata !== '0 ||
        m_axi_awprot !== 3'b000 || m_axi_wstrb !== 4'b1111) begin
      n_errors++;
      $display("[TB] FAIL reset_datapath: awaddr=%h araddr=%h wdata=%h prot=%b strb=%b, required %h,%h,0,000,1111",
               m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_awprot, m_axi_wstrb, BASE, BASE);
    end
    s_axi_aresetn = 1;
    repeat (2) @(negedge s_axi_aclk);
  endtask

  task automatic test_basic;
    aw_delay = 0; w_delay = 0;
    do_load("basic", 1, 0, -1, -1, 0);
  endtask

  task automatic test_handshake_skew;
    aw_delay = 3; w_delay = 0;
    do_load("w_before_aw", 0, 0, -1, -1, 0);
    aw_delay = 0; w_delay = 2;
    do_load("aw_before_w", 0, 0, -1, -1, 0);
    aw_delay = 2; w_delay = 2;
    do_load("aw_w_together", 0, 0, -1, -1, 0);
  endtask

  task automatic test_stream_gaps;
    aw_delay = 0; w_delay = 0;
    do_load("stream_gaps", 0, 50, -1, -1, 1);
  endtask

  task automatic test_bresp_error;
    aw_delay = 1; w_delay = 0;
    do_load("bresp_err", 0, 2, 2, -1, 0);
    do_load("err_cleared", 0, 2, -1, -1, 0);
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    int cyc;
    aw_delay = 30; w_delay = 0;
    start = 1; @(negedge s_axi_aclk); start = 0;
    for (int i = 0; i < 4; i++) begin
      send_word($urandom, 0, ok);
      if (!ok) begin
        n_checks++; n_errors++;
        $display("[TB] FAIL reset_mid stream_word%0d: in_ready timeout, required ready", i);
        return;
      end
    end
    cyc = 0;
    while (!m_axi_awvalid && cyc < WAIT_LIMIT) begin @(negedge s_axi_aclk); cyc++; end
    n_checks++;
    if (m_axi_awvalid !== 1'b1 || word_count !== CNT_W'(3)) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_pre: awvalid=%b wc=%0d, required 1,3", m_axi_awvalid, word_count);
    end
    #2 s_axi_aresetn = 0;
    #1;
    n_checks++;
    if (m_axi_awvalid !== 0 || m_axi_wvalid !== 0 || busy !== 0 || word_count !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_drop: awvalid=%b wvalid=%b busy=%b wc=%0d, required 0,0,0,0",
               m_axi_awvalid, m_axi_wvalid, busy, word_count);
    end
    repeat (2) @(negedge s_axi_aclk);
    s_axi_aresetn = 1;
    aw_delay = 0;
    @(negedge s_axi_aclk);
    do_load("after_reset", 0, 3, -1, -1, 0);
  endtask

`ifdef AXIL_LOADER_READBACK_EN
  task automatic test_readback_corrupt;
    aw_delay = 0; w_delay = 0;
    do_load("readback_corrupt", 0, 1, -1, 1, 0);
    do_load("readback_clean", 0, 1, -1, -1, 0);
  endtask
`endif

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      aw_delay = $urandom_range(0, 4);
      w_delay  = $urandom_range(0, 4);
      do_load("back_to_back", 0, 0, -1, -1, 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_handshake_skew();
    test_stream_gaps();
    test_bresp_error();
    test_reset_mid_load();
`ifdef AXIL_LOADER_READBACK_EN
    test_readback_corrupt();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
